// File: rtl/asrv32_core_sequencer_pkg.sv
// Shared definitions for the ASRV32 core sequencer: state encoding, one-hot
// opcode bit positions, trap cause codes and the opcode legality helper.
package asrv32_core_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd6,
    ST_TRAP      = 3'd7
  } state_t;

  localparam int OPCODE_WIDTH = 11;

  localparam int OP_LOAD   = 0;
  localparam int OP_STORE  = 1;
  localparam int OP_BRANCH = 2;
  localparam int OP_JAL    = 3;
  localparam int OP_JALR   = 4;
  localparam int OP_LUI    = 5;
  localparam int OP_AUIPC  = 6;
  localparam int OP_ITYPE  = 7;
  localparam int OP_RTYPE  = 8;
  localparam int OP_FENCE  = 9;
  localparam int OP_SYSTEM = 10;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_SYSTEM  = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

  // Opcodes whose result is written back to the register file.
  localparam logic [OPCODE_WIDTH-1:0] WB_MASK = OPCODE_WIDTH'(
    (1 << OP_RTYPE) | (1 << OP_ITYPE) | (1 << OP_LOAD) | (1 << OP_JAL) |
    (1 << OP_JALR)  | (1 << OP_LUI)   | (1 << OP_AUIPC));

  function automatic logic is_onehot(input logic [OPCODE_WIDTH-1:0] v);
    return (v != '0) && ((v & (v - {{(OPCODE_WIDTH-1){1'b0}}, 1'b1})) == '0);
  endfunction

endpackage

// File: rtl/asrv32_mem_timer.sv
// Shared memory-request watchdog: counts cycles without ack while enabled and
// flags expiry on the last permitted cycle. Saturates instead of wrapping.
module asrv32_mem_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMR_W       = 5
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_en,
  input  logic i_ack,
  output logic o_expired
);

  localparam logic [TMR_W-1:0] LIMIT = TMR_W'(MEM_TIMEOUT - 1);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_en && !i_ack && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // An ack on the limit cycle still counts as success.
  assign o_expired = i_en && !i_ack && (cnt_q == LIMIT);

endmodule

// File: rtl/asrv32_core_sequencer.sv
// Multi-cycle control FSM for the ASRV32 core (FETCH/DECODE/EXECUTE/MEMORY/
// WRITEBACK). Optional retired-instruction counter under ASRV32_INSTRET_EN.
module asrv32_core_sequencer
  import asrv32_core_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMR_W       = 5
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [OPCODE_WIDTH-1:0] i_opcode,
  input  logic                    i_imem_ack,
  input  logic                    i_dmem_ack,
  input  logic                    i_halt,
  output logic                    o_imem_req,
  output logic                    o_dmem_req,
  output logic                    o_dec_ce,
  output logic                    o_alu_ce,
  output logic                    o_wb_en,
  output logic                    o_pc_ce,
  output logic                    o_halted,
  output logic                    o_trap,
  output logic [1:0]              o_trap_cause,
`ifdef ASRV32_INSTRET_EN
  output logic [63:0]             o_instret,
`endif
  output state_t                  o_dbg_state
);

  state_t     state_q, state_d;
  logic [1:0] cause_q, cause_d;
  logic       wb_sel_q, wb_sel_d;
  logic       in_mem_wait;
  logic       tmr_ack;
  logic       tmr_expired;

  assign in_mem_wait = (state_q == ST_FETCH) || (state_q == ST_MEMORY);
  assign tmr_ack     = (state_q == ST_FETCH) ? i_imem_ack : i_dmem_ack;

  asrv32_mem_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TMR_W       (TMR_W)
  ) u_mem_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (!in_mem_wait),
    .i_en      (in_mem_wait),
    .i_ack     (tmr_ack),
    .o_expired (tmr_expired)
  );

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    wb_sel_d = wb_sel_q;
    case (state_q)
      ST_RESET:     state_d = ST_FETCH;
      ST_FETCH: begin
        if (i_imem_ack) begin
          state_d = ST_DECODE;
        end else if (tmr_expired) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_DECODE:    state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        // The write-back decision is captured here so WRITEBACK outputs stay
        // purely registered.
        wb_sel_d = |(i_opcode & WB_MASK);
        if (!is_onehot(i_opcode)) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else if (i_opcode[OP_SYSTEM]) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_SYSTEM;
        end else if (i_opcode[OP_LOAD] || i_opcode[OP_STORE]) begin
          state_d = ST_MEMORY;
        end else begin
          state_d = ST_WRITEBACK;
        end
      end
      ST_MEMORY: begin
        if (i_dmem_ack) begin
          state_d = ST_WRITEBACK;
        end else if (tmr_expired) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_WRITEBACK: state_d = i_halt ? ST_HALT : ST_FETCH;
      ST_HALT:      state_d = i_halt ? ST_HALT : ST_FETCH;
      ST_TRAP:      state_d = ST_TRAP;
      default:      state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_RESET;
      cause_q  <= CAUSE_NONE;
      wb_sel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      wb_sel_q <= wb_sel_d;
    end
  end

`ifdef ASRV32_INSTRET_EN
  logic [63:0] instret_q, instret_d;

  always_comb begin
    instret_d = instret_q;
    if (state_q == ST_WRITEBACK) begin
      instret_d = instret_q + 64'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign o_instret = instret_q;
`endif

  assign o_imem_req   = (state_q == ST_FETCH);
  assign o_dmem_req   = (state_q == ST_MEMORY);
  assign o_dec_ce     = (state_q == ST_DECODE);
  assign o_alu_ce     = (state_q == ST_EXECUTE);
  assign o_wb_en      = (state_q == ST_WRITEBACK) && wb_sel_q;
  assign o_pc_ce      = (state_q == ST_WRITEBACK);
  assign o_halted     = (state_q == ST_HALT);
  assign o_trap       = (state_q == ST_TRAP);
  assign o_trap_cause = cause_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_asrv32_core_sequencer.sv
// Bench for asrv32_core_sequencer: directed vector table driven reactively,
// then randomized instruction streams checked cycle by cycle against a model.
module tb_asrv32_core_sequencer;
  import asrv32_core_sequencer_pkg::*;

  localparam int TMO = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic imem_ack, dmem_ack, halt;
  logic o_imem_req, o_dmem_req, o_dec_ce, o_alu_ce, o_wb_en, o_pc_ce;
  logic o_halted, o_trap;
  logic [1:0] o_trap_cause;
  state_t dbg_state;
`ifdef ASRV32_INSTRET_EN
  logic [63:0] instret;
`endif

  always #5 clk = ~clk;

  asrv32_core_sequencer #(.MEM_TIMEOUT(TMO), .TMR_W(5)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_opcode     (opcode),
    .i_imem_ack   (imem_ack),
    .i_dmem_ack   (dmem_ack),
    .i_halt       (halt),
    .o_imem_req   (o_imem_req),
    .o_dmem_req   (o_dmem_req),
    .o_dec_ce     (o_dec_ce),
    .o_alu_ce     (o_alu_ce),
    .o_wb_en      (o_wb_en),
    .o_pc_ce      (o_pc_ce),
    .o_halted     (o_halted),
    .o_trap       (o_trap),
    .o_trap_cause (o_trap_cause),
`ifdef ASRV32_INSTRET_EN
    .o_instret    (instret),
`endif
    .o_dbg_state  (dbg_state)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output vector: {imem_req,dmem_req,dec_ce,alu_ce,wb_en,pc_ce,halted,trap,cause[1:0]}
  localparam logic [9:0] E_IDLE  = 10'b0000000000;
  localparam logic [9:0] E_FETCH = 10'b1000000000;
  localparam logic [9:0] E_MEM   = 10'b0100000000;
  localparam logic [9:0] E_DEC   = 10'b0010000000;
  localparam logic [9:0] E_EXE   = 10'b0001000000;
  localparam logic [9:0] E_WBEN  = 10'b0000100000;
  localparam logic [9:0] E_PCCE  = 10'b0000010000;
  localparam logic [9:0] E_HALT  = 10'b0000001000;
  localparam logic [9:0] E_TRAP  = 10'b0000000100;

  function automatic logic [9:0] outs_now();
    return {o_imem_req, o_dmem_req, o_dec_ce, o_alu_ce, o_wb_en, o_pc_ce,
            o_halted, o_trap, o_trap_cause};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [OPCODE_WIDTH-1:0] rop();
    return OPCODE_WIDTH'($urandom);
  endfunction

  function automatic logic [OPCODE_WIDTH-1:0] oh(input int idx);
    logic [OPCODE_WIDTH-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // ---------------- reference model: per-cycle expectation queues ----------------
  logic [9:0]  exp_q[$];
  logic [14:0] stim_q[$];
  logic [63:0] ir_q[$];
  logic [63:0] ir_cnt;

  task automatic push(input logic [9:0] e, input logic r, input logic ia, input logic da,
                      input logic h, input logic [OPCODE_WIDTH-1:0] op);
    exp_q.push_back(e);
    stim_q.push_back({r, ia, da, h, op});
    ir_q.push_back(ir_cnt);
  endtask

  // One instruction from its first FETCH cycle. iw/dw: ack arrives in that many
  // waiting cycles (>= TMO means never). abort_at >= 0 asserts reset in that
  // MEMORY cycle. Ends with the DUT about to be in FETCH again.
  task automatic gen_instr(input logic [OPCODE_WIDTH-1:0] op, input int iw, input int dw,
                           input bit h, input int hlen, input int abort_at);
    bit trapped;
    logic [1:0] cause;
    bit writes;
    int n;
    trapped = 0;
    cause   = 2'd0;
    for (int k = 0; k < TMO; k++) begin
      if (k == iw) begin
        push(E_FETCH, 0, 1, rb(), rb(), rop());
        break;
      end
      push(E_FETCH, 0, 0, rb(), rb(), rop());
      if (k == TMO - 1) begin
        trapped = 1;
        cause   = 2'd3;
      end
    end
    if (!trapped) begin
      push(E_DEC, 0, rb(), rb(), rb(), rop());
      push(E_EXE, 0, rb(), rb(), rb(), op);
      if ($countones(op) != 1) begin
        trapped = 1;
        cause   = 2'd1;
      end else if (op[OP_SYSTEM]) begin
        trapped = 1;
        cause   = 2'd2;
      end else begin
        if (op[OP_LOAD] || op[OP_STORE]) begin
          for (int k = 0; k < TMO; k++) begin
            if (k == abort_at) begin
              push(E_MEM, 1, rb(), 0, rb(), op);
              ir_cnt = '0;
              push(E_IDLE, 0, rb(), rb(), rb(), rop());
              return;
            end
            if (k == dw) begin
              push(E_MEM, 0, rb(), 1, rb(), op);
              break;
            end
            push(E_MEM, 0, rb(), 0, rb(), op);
            if (k == TMO - 1) begin
              trapped = 1;
              cause   = 2'd3;
            end
          end
        end
        if (!trapped) begin
          writes = op[OP_RTYPE] | op[OP_ITYPE] | op[OP_LOAD] | op[OP_JAL] |
                   op[OP_JALR] | op[OP_LUI] | op[OP_AUIPC];
          push(E_PCCE | (writes ? E_WBEN : E_IDLE), 0, rb(), rb(), h, op);
          ir_cnt = ir_cnt + 64'd1;
          if (h) begin
            for (int j = 0; j < hlen; j++) begin
              push(E_HALT, 0, rb(), rb(), (j != hlen - 1), rop());
            end
          end
          return;
        end
      end
    end
    // Trap is sticky until a reset, after which one RESET cycle precedes FETCH.
    n = $urandom_range(2, 8);
    for (int j = 0; j < n; j++) begin
      push(E_TRAP | {8'd0, cause}, (j == n - 1), rb(), rb(), rb(), rop());
    end
    ir_cnt = '0;
    push(E_IDLE, 0, rb(), rb(), rb(), rop());
  endtask

  // ---------------- driver: replay queues, compare each cycle ----------------
  task automatic play();
    logic [9:0]  e;
    logic [14:0] s;
    logic [63:0] ir;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      s  = stim_q.pop_front();
      ir = ir_q.pop_front();
      check("seq_outs", 64'(outs_now()), 64'(e));
`ifdef ASRV32_INSTRET_EN
      check("seq_instret", instret, ir);
`else
      if (ir === 'x) $display("instret model undefined");
`endif
      {rst, imem_ack, dmem_ack, halt, opcode} = s;
      @(negedge clk);
    end
    {rst, imem_ack, dmem_ack, halt} = 4'b0000;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [OPCODE_WIDTH-1:0] op;
    int         iw;
    int         dw;
    bit         exp_wb;
    logic [1:0] exp_cause;
    int         exp_len;   // cycles up to and including pc_ce, or before trap shows
    int         exp_dreq;
  } vec_t;

  vec_t vecs[16];

  task automatic run_vec(input vec_t v, input int idx);
    int cyc, fcnt, mcnt, dreq;
    bit done, got_trap;
    cyc = 0; fcnt = 0; mcnt = 0; dreq = 0; done = 0; got_trap = 0;
    opcode = v.op;
    while (!done && cyc < 80) begin
      imem_ack = 0; dmem_ack = 0; halt = 0;
      if (o_trap) begin
        got_trap = 1;
        done = 1;
        check($sformatf("vec%0d_len", idx), 64'(cyc), 64'(v.exp_len));
      end else if (o_pc_ce) begin
        done = 1;
        check($sformatf("vec%0d_len", idx), 64'(cyc + 1), 64'(v.exp_len));
        check($sformatf("vec%0d_wb_en", idx), 64'(o_wb_en), 64'(v.exp_wb));
      end else begin
        if (o_imem_req) begin imem_ack = (fcnt == v.iw); fcnt++; end
        if (o_dmem_req) begin dmem_ack = (mcnt == v.dw); mcnt++; dreq++; end
        @(negedge clk);
        cyc++;
      end
    end
    check($sformatf("vec%0d_finished", idx), 64'(done), 64'd1);
    check($sformatf("vec%0d_cause", idx), 64'(o_trap_cause), 64'(v.exp_cause));
    check($sformatf("vec%0d_dmem_req_cycles", idx), 64'(dreq), 64'(v.exp_dreq));
    imem_ack = 0; dmem_ack = 0;
    @(negedge clk);
    if (got_trap) begin
      for (int j = 0; j < 20; j++) begin
        check($sformatf("vec%0d_trap_quiet", idx),
              64'({o_imem_req, o_dmem_req, o_trap, o_trap_cause}),
              64'({2'b00, 1'b1, v.exp_cause}));
        imem_ack = rb(); dmem_ack = rb();
        @(negedge clk);
      end
      imem_ack = 0; dmem_ack = 0;
      rst = 1;
      @(negedge clk);
      check($sformatf("vec%0d_reset_outs", idx), 64'(outs_now()), 64'(E_IDLE));
      rst = 0;
      @(negedge clk);
    end
    check($sformatf("vec%0d_next_fetch", idx), 64'(o_imem_req), 64'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int r, iw, dw, hl, ab;
    bit h;
    logic [OPCODE_WIDTH-1:0] op;

    rst = 1; imem_ack = 0; dmem_ack = 0; halt = 0; opcode = '0;
    ir_cnt = '0;
    repeat (3) @(negedge clk);
    check("reset_outs", 64'(outs_now()), 64'(E_IDLE));
    check("reset_state", 64'(dbg_state), 64'(ST_RESET));
`ifdef ASRV32_INSTRET_EN
    check("reset_instret", instret, 64'd0);
`endif
    rst = 0;
    @(negedge clk);
    check("first_fetch", 64'(outs_now()), 64'(E_FETCH));

    //          op                                  iw  dw  wb cause len dreq
    vecs[0]  = '{oh(OP_ITYPE),                       0,  0, 1, 2'd0,  4,  0};
    vecs[1]  = '{oh(OP_LOAD),                        0,  3, 1, 2'd0,  8,  4};
    vecs[2]  = '{oh(OP_STORE),                       0,  3, 0, 2'd0,  8,  4};
    vecs[3]  = '{'0,                                 0,  0, 0, 2'd1,  3,  0};
    vecs[4]  = '{oh(OP_LOAD) | oh(OP_STORE),         1,  0, 0, 2'd1,  4,  0};
    vecs[5]  = '{oh(OP_SYSTEM),                      0,  0, 0, 2'd2,  3,  0};
    vecs[6]  = '{oh(OP_FENCE),                       0,  0, 0, 2'd0,  4,  0};
    vecs[7]  = '{oh(OP_BRANCH),                      2,  0, 0, 2'd0,  6,  0};
    vecs[8]  = '{oh(OP_JAL),                         1,  0, 1, 2'd0,  5,  0};
    vecs[9]  = '{oh(OP_ITYPE),                      99,  0, 0, 2'd3, 16,  0};
    vecs[10] = '{oh(OP_ITYPE),                      15,  0, 1, 2'd0, 19,  0};
    vecs[11] = '{oh(OP_LOAD),                        0, 99, 0, 2'd3, 19, 16};
    vecs[12] = '{oh(OP_LOAD),                        0, 15, 1, 2'd0, 20, 16};
    vecs[13] = '{oh(OP_RTYPE),                       3,  0, 1, 2'd0,  7,  0};
    vecs[14] = '{oh(OP_LUI),                         0,  0, 1, 2'd0,  4,  0};
    vecs[15] = '{oh(OP_AUIPC) | oh(OP_JALR),         0,  0, 0, 2'd1,  3,  0};

    for (int i = 0; i < 16; i++) begin
      run_vec(vecs[i], i);
    end

    // Bring instret model in line: restart from a known reset.
    rst = 1;
    @(negedge clk);
    rst = 0;
    ir_cnt = '0;
    @(negedge clk);

    // Halt after WRITEBACK, then release; next instruction follows.
    gen_instr(oh(OP_ITYPE), 0, 0, 1, 3, -1);
    gen_instr(oh(OP_JALR), 1, 0, 1, 1, -1);
    gen_instr(oh(OP_STORE), 0, 2, 0, 0, -1);
    // Reset while waiting in MEMORY, then a clean restart.
    gen_instr(oh(OP_LOAD), 0, 5, 0, 0, 2);
    gen_instr(oh(OP_LOAD), 0, 0, 0, 0, -1);
    play();

    // Randomized instruction streams.
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 12);
      if (r <= 10)      op = oh(r);
      else if (r == 11) op = '0;
      else              op = rop();
      iw = ($urandom_range(0, 19) == 0) ? $urandom_range(13, 20) : $urandom_range(0, 4);
      dw = ($urandom_range(0, 19) == 0) ? $urandom_range(13, 20) : $urandom_range(0, 4);
      h  = ($urandom_range(0, 4) == 0);
      hl = $urandom_range(1, 4);
      ab = -1;
      if (dw > 0 && $urandom_range(0, 14) == 0) ab = $urandom_range(0, ((dw < TMO) ? dw : TMO) - 1);
      gen_instr(op, iw, dw, h, hl, ab);
      play();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
